// File: rtl/vect_pkg.sv
// Shared opcode encoding, sequencer state type and opcode classification helpers
// for the vector logic sequencer. Opcodes are {op[4:0], type[1:0]}.
package vect_pkg;

  localparam logic [1:0] TYPE_INT  = 2'b00;
  localparam logic [1:0] TYPE_FP   = 2'b01;
  localparam logic [1:0] TYPE_MULT = 2'b10;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_NAND   = 5'd5;
  localparam logic [4:0] OP_ANDNOT = 5'd6;
  localparam logic [4:0] OP_NOR    = 5'd7;
  localparam logic [4:0] OP_ORNOT  = 5'd8;
  localparam logic [4:0] OP_XNOR   = 5'd9;

  localparam logic [6:0] VADD     = {OP_ADD,    TYPE_INT};
  localparam logic [6:0] VAND     = {OP_AND,    TYPE_INT};
  localparam logic [6:0] VOR      = {OP_OR,     TYPE_INT};
  localparam logic [6:0] VXOR     = {OP_XOR,    TYPE_INT};
  localparam logic [6:0] VMAND    = {OP_AND,    TYPE_MULT};
  localparam logic [6:0] VMOR     = {OP_OR,     TYPE_MULT};
  localparam logic [6:0] VMXOR    = {OP_XOR,    TYPE_MULT};
  localparam logic [6:0] VMNAND   = {OP_NAND,   TYPE_MULT};
  localparam logic [6:0] VMANDNOT = {OP_ANDNOT, TYPE_MULT};
  localparam logic [6:0] VMNOR    = {OP_NOR,    TYPE_MULT};
  localparam logic [6:0] VMORNOT  = {OP_ORNOT,  TYPE_MULT};
  localparam logic [6:0] VMXNOR   = {OP_XNOR,   TYPE_MULT};

  typedef enum logic [2:0] {IDLE, RD, EX, WB, DONE} vlogic_state_e;

  function automatic logic is_logic_ocode(input logic [6:0] ocode);
    case (ocode)
      VAND, VOR, VXOR,
      VMAND, VMOR, VMXOR, VMNAND, VMANDNOT, VMNOR, VMORNOT, VMXNOR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_mask_ocode(input logic [6:0] ocode);
    return ocode[1:0] == TYPE_MULT;
  endfunction

endpackage

// File: rtl/vlogic_seq_if.sv
// Issue, VRF and logic-unit signals of the vector logic sequencer.
// Signal suffixes are from the sequencer's point of view (slave modport).
interface vlogic_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int VL_WIDTH   = 7,
  parameter int BEAT_W     = 6
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [6:0]            req_ocode_i;
  logic [VL_WIDTH-1:0]   req_vl_i;
  logic [4:0]            req_vs1_i;
  logic [4:0]            req_vs2_i;
  logic [4:0]            req_vd_i;
  logic                  done_o;
  logic                  err_o;
  logic                  rd_req_o;
  logic [5+BEAT_W-1:0]   rd_addr1_o;
  logic [5+BEAT_W-1:0]   rd_addr2_o;
  logic                  rd_valid_i;
  logic [DATA_WIDTH-1:0] rd_data1_i;
  logic [DATA_WIDTH-1:0] rd_data2_i;
  logic                  logic_e_o;
  logic [DATA_WIDTH-1:0] logic_a_o;
  logic [DATA_WIDTH-1:0] logic_b_o;
  logic [6:0]            logic_ocode_o;
  logic [DATA_WIDTH-1:0] logic_result_i;
  logic                  wr_req_o;
  logic [5+BEAT_W-1:0]   wr_addr_o;
  logic [DATA_WIDTH-1:0] wr_data_o;
  logic [DATA_WIDTH-1:0] wr_bmask_o;
  logic                  wr_ack_i;

  modport slave (
    input  req_valid_i, req_ocode_i, req_vl_i, req_vs1_i, req_vs2_i, req_vd_i,
    input  rd_valid_i, rd_data1_i, rd_data2_i, logic_result_i, wr_ack_i,
    output req_ready_o, done_o, err_o, rd_req_o, rd_addr1_o, rd_addr2_o,
    output logic_e_o, logic_a_o, logic_b_o, logic_ocode_o,
    output wr_req_o, wr_addr_o, wr_data_o, wr_bmask_o
  );

  modport master (
    output req_valid_i, req_ocode_i, req_vl_i, req_vs1_i, req_vs2_i, req_vd_i,
    output rd_valid_i, rd_data1_i, rd_data2_i, logic_result_i, wr_ack_i,
    input  req_ready_o, done_o, err_o, rd_req_o, rd_addr1_o, rd_addr2_o,
    input  logic_e_o, logic_a_o, logic_b_o, logic_ocode_o,
    input  wr_req_o, wr_addr_o, wr_data_o, wr_bmask_o
  );
endinterface

// File: rtl/vlogic_seq_tailmask.sv
// Write bit-mask for the sequencer: all ones except on the last beat of a
// mask op, where only the bits below vl mod DATA_WIDTH are enabled.
module vlogic_tailmask #(
  parameter int DATA_WIDTH = 32,
  parameter int VL_WIDTH   = 7
) (
  input  logic [VL_WIDTH-1:0]   i_vl,
  input  logic                  i_last_mask,
  output logic [DATA_WIDTH-1:0] o_bmask
);
  logic [VL_WIDTH-1:0] w_rem;

  assign w_rem = i_vl % VL_WIDTH'(DATA_WIDTH);

  always_comb begin
    o_bmask = '1;
    if (i_last_mask && (w_rem != '0)) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        o_bmask[i] = (i < int'(w_rem));
      end
    end
  end
endmodule

// File: rtl/vlogic_seq.sv
// Vector logic sequencer: walks one logic instruction through VRF read, logic
// evaluation and write-back per beat. Optional macro VLOGIC_SEQ_PERF_EN adds perf counters.
module vlogic_seq
  import vect_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_VL     = 64,
  parameter int VL_WIDTH   = $clog2(MAX_VL + 1),
  parameter int BEAT_W     = $clog2(MAX_VL)
) (
  input  logic        module_clk_i,
  input  logic        module_rst_i,
  vlogic_seq_if.slave bus
`ifdef VLOGIC_SEQ_PERF_EN
  ,
  output logic [31:0] perf_busy_cycles_o,
  output logic [31:0] perf_beats_o
`endif
);
  localparam int RW = $clog2(DATA_WIDTH);

  vlogic_state_e         r_state;
  logic [6:0]            r_ocode;
  logic [VL_WIDTH-1:0]   r_vl;
  logic [4:0]            r_vs1, r_vs2, r_vd;
  logic [VL_WIDTH-1:0]   r_beat;
  logic [VL_WIDTH-1:0]   r_nbeats;
  logic                  r_mask_op;
  logic                  r_ready, r_done, r_err, r_rd_req, r_le, r_wr_req;
  logic [DATA_WIDTH-1:0] r_a, r_b, r_wdata;
  logic [6:0]            r_logic_ocode;

  logic [VL_WIDTH:0]     w_vl_round;
  logic [VL_WIDTH-1:0]   w_nbeats;
  logic                  w_req_mask, w_req_legal, w_last;
  logic [DATA_WIDTH-1:0] w_bmask;

  assign w_req_mask  = is_mask_ocode(bus.req_ocode_i);
  assign w_req_legal = is_logic_ocode(bus.req_ocode_i);
  assign w_vl_round  = {1'b0, bus.req_vl_i} + (VL_WIDTH+1)'(DATA_WIDTH - 1);
  assign w_nbeats    = w_req_mask ? VL_WIDTH'(w_vl_round >> RW) : bus.req_vl_i;
  assign w_last      = (r_beat + VL_WIDTH'(1)) == r_nbeats;

  vlogic_tailmask #(.DATA_WIDTH(DATA_WIDTH), .VL_WIDTH(VL_WIDTH)) u_tailmask (
    .i_vl        (r_vl),
    .i_last_mask (w_last & r_mask_op),
    .o_bmask     (w_bmask)
  );

  always_ff @(posedge module_clk_i) begin
    if (module_rst_i) begin
      r_state       <= IDLE;
      r_ocode       <= '0;
      r_vl          <= '0;
      r_vs1         <= '0;
      r_vs2         <= '0;
      r_vd          <= '0;
      r_beat        <= '0;
      r_nbeats      <= '0;
      r_mask_op     <= 1'b0;
      r_ready       <= 1'b1;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_rd_req      <= 1'b0;
      r_le          <= 1'b0;
      r_wr_req      <= 1'b0;
      r_a           <= '0;
      r_b           <= '0;
      r_wdata       <= '0;
      r_logic_ocode <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: if (bus.req_valid_i) begin
          r_ocode   <= bus.req_ocode_i;
          r_vl      <= bus.req_vl_i;
          r_vs1     <= bus.req_vs1_i;
          r_vs2     <= bus.req_vs2_i;
          r_vd      <= bus.req_vd_i;
          r_beat    <= '0;
          r_nbeats  <= w_nbeats;
          r_mask_op <= w_req_mask;
          r_ready   <= 1'b0;
          // Illegal opcodes and empty vectors retire without touching the VRF.
          if (!w_req_legal || (bus.req_vl_i == '0)) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_err   <= !w_req_legal;
          end else begin
            r_state  <= RD;
            r_rd_req <= 1'b1;
          end
        end
        RD: if (bus.rd_valid_i) begin
          r_rd_req      <= 1'b0;
          r_a           <= bus.rd_data1_i;
          r_b           <= bus.rd_data2_i;
          r_logic_ocode <= r_ocode;
          r_le          <= 1'b1;
          r_state       <= EX;
        end
        EX: begin
          r_wdata       <= bus.logic_result_i;
          r_le          <= 1'b0;
          r_a           <= '0;
          r_b           <= '0;
          r_logic_ocode <= '0;
          r_wr_req      <= 1'b1;
          r_state       <= WB;
        end
        WB: if (bus.wr_ack_i) begin
          r_wr_req <= 1'b0;
          r_beat   <= r_beat + VL_WIDTH'(1);
          if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state  <= RD;
            r_rd_req <= 1'b1;
          end
        end
        DONE: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready_o   = r_ready;
  assign bus.done_o        = r_done;
  assign bus.err_o         = r_err;
  assign bus.rd_req_o      = r_rd_req;
  assign bus.rd_addr1_o    = {r_vs1, r_beat[BEAT_W-1:0]};
  assign bus.rd_addr2_o    = {r_vs2, r_beat[BEAT_W-1:0]};
  assign bus.logic_e_o     = r_le;
  assign bus.logic_a_o     = r_a;
  assign bus.logic_b_o     = r_b;
  assign bus.logic_ocode_o = r_logic_ocode;
  assign bus.wr_req_o      = r_wr_req;
  assign bus.wr_addr_o     = {r_vd, r_beat[BEAT_W-1:0]};
  assign bus.wr_data_o     = r_wdata;
  assign bus.wr_bmask_o    = r_wr_req ? w_bmask : '0;

`ifdef VLOGIC_SEQ_PERF_EN
  logic [31:0] r_perf_busy, r_perf_beats;

  always_ff @(posedge module_clk_i) begin
    if (module_rst_i) begin
      r_perf_busy  <= '0;
      r_perf_beats <= '0;
    end else begin
      if ((r_state != IDLE) && (r_perf_busy != '1)) r_perf_busy <= r_perf_busy + 32'd1;
      if ((r_state == WB) && bus.wr_ack_i && (r_perf_beats != '1)) r_perf_beats <= r_perf_beats + 32'd1;
    end
  end

  assign perf_busy_cycles_o = r_perf_busy;
  assign perf_beats_o       = r_perf_beats;
`endif
endmodule

// File: tb/tb_vlogic_seq.sv
// Directed bench for vlogic_seq: table of instruction vectors with hand-computed
// write data, masks, error flag and latency, plus a delayed-handshake/reset sequence.
module tb_vlogic_seq;
  import vect_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vlogic_seq_if #(.DATA_WIDTH(32), .VL_WIDTH(7), .BEAT_W(6)) bus ();

`ifdef VLOGIC_SEQ_PERF_EN
  logic [31:0] perf_busy, perf_beats;
`endif

  vlogic_seq #(.DATA_WIDTH(32), .MAX_VL(64)) dut (
    .module_clk_i (clk),
    .module_rst_i (rst),
    .bus          (bus.slave)
`ifdef VLOGIC_SEQ_PERF_EN
    ,
    .perf_busy_cycles_o (perf_busy),
    .perf_beats_o       (perf_beats)
`endif
  );

  // Logic unit stand-in; andnot/ornot follow vd = vs2 op ~vs1.
  always_comb begin
    case (bus.logic_ocode_o[6:2])
      OP_AND:    bus.logic_result_i = bus.logic_a_o & bus.logic_b_o;
      OP_OR:     bus.logic_result_i = bus.logic_a_o | bus.logic_b_o;
      OP_XOR:    bus.logic_result_i = bus.logic_a_o ^ bus.logic_b_o;
      OP_NAND:   bus.logic_result_i = ~(bus.logic_a_o & bus.logic_b_o);
      OP_ANDNOT: bus.logic_result_i = bus.logic_b_o & ~bus.logic_a_o;
      OP_NOR:    bus.logic_result_i = ~(bus.logic_a_o | bus.logic_b_o);
      OP_ORNOT:  bus.logic_result_i = bus.logic_b_o | ~bus.logic_a_o;
      OP_XNOR:   bus.logic_result_i = ~(bus.logic_a_o ^ bus.logic_b_o);
      default:   bus.logic_result_i = '0;
    endcase
  end

  int total = 0;
  int bad   = 0;

  int rd_dly = 0;
  int wr_dly = 0;
  int done_cnt = 0, done_cyc = 0, stray_err = 0, rd_cycles = 0, le_cycles = 0, wr_n = 0;
  logic done_err = 1'b0;
  logic [10:0] log_addr [256];
  logic [31:0] log_data [256];
  logic [31:0] log_mask [256];

  // VRF responder and event monitor, all on the falling edge.
  initial begin
    int rcnt, wcnt;
    rcnt = 0;
    wcnt = 0;
    bus.rd_valid_i = 1'b0;
    bus.wr_ack_i   = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done_o) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = bus.err_o;
      end
      if (bus.err_o && !bus.done_o) stray_err++;
      if (bus.rd_req_o) rd_cycles++;
      if (bus.logic_e_o) le_cycles++;
      if (bus.rd_req_o) begin
        bus.rd_valid_i = (rcnt >= rd_dly);
        rcnt++;
      end else begin
        bus.rd_valid_i = 1'b0;
        rcnt = 0;
      end
      if (bus.wr_req_o) begin
        if (wcnt >= wr_dly) begin
          bus.wr_ack_i = 1'b1;
          log_addr[wr_n % 256] = bus.wr_addr_o;
          log_data[wr_n % 256] = bus.wr_data_o;
          log_mask[wr_n % 256] = bus.wr_bmask_o;
          wr_n++;
        end else begin
          bus.wr_ack_i = 1'b0;
        end
        wcnt++;
      end else begin
        bus.wr_ack_i = 1'b0;
        wcnt = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got cyc=%0d want finish", cyc);
    $fatal(1);
  end

  typedef struct {
    logic [6:0]  ocode;
    logic [6:0]  vl;
    logic [4:0]  vs1, vs2, vd;
    logic [31:0] a, b;
    int          nwr;
    logic [31:0] data;
    logic [31:0] last_mask;
    logic        err;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v, output int acc_cyc);
    int t;
    @(negedge clk);
    bus.rd_data1_i  = v.a;
    bus.rd_data2_i  = v.b;
    bus.req_ocode_i = v.ocode;
    bus.req_vl_i    = v.vl;
    bus.req_vs1_i   = v.vs1;
    bus.req_vs2_i   = v.vs2;
    bus.req_vd_i    = v.vd;
    bus.req_valid_i = 1'b1;
    t = 0;
    while (!bus.req_ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    acc_cyc = cyc + 1;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int acc, t, b_done, b_rd, b_le, b_wr, exp_lat;
    logic [10:0] exp_addr;
    logic [31:0] exp_mask;
    b_done = done_cnt;
    b_rd   = rd_cycles;
    b_le   = le_cycles;
    b_wr   = wr_n;
    run_req(v, acc);
    #1;
    t = 0;
    while (done_cnt == b_done && t < 3000) begin
      @(negedge clk);
      #1;
      t++;
    end
    exp_lat = v.nwr * (3 + rd_dly + wr_dly);
    check({tag, " latency"}, 64'(done_cyc - acc), 64'(exp_lat));
    check({tag, " err"}, 64'(done_err), 64'(v.err));
    check({tag, " ready low at done"}, 64'(bus.req_ready_o), 64'd0);
    check({tag, " writes"}, 64'(wr_n - b_wr), 64'(v.nwr));
    check({tag, " logic_e cycles"}, 64'(le_cycles - b_le), 64'(v.nwr));
    if (v.nwr == 0) check({tag, " rd cycles"}, 64'(rd_cycles - b_rd), 64'd0);
    for (int i = 0; i < v.nwr && i < (wr_n - b_wr); i++) begin
      exp_addr = {v.vd, 6'(i)};
      exp_mask = (i == v.nwr - 1) ? v.last_mask : 32'hFFFF_FFFF;
      check($sformatf("%s addr[%0d]", tag, i), 64'(log_addr[(b_wr + i) % 256]), 64'(exp_addr));
      check($sformatf("%s data[%0d]", tag, i), 64'(log_data[(b_wr + i) % 256]), 64'(v.data));
      check($sformatf("%s bmask[%0d]", tag, i), 64'(log_mask[(b_wr + i) % 256]), 64'(exp_mask));
    end
    @(negedge clk);
    #1;
    check({tag, " ready back"}, 64'(bus.req_ready_o), 64'd1);
    check({tag, " single done"}, 64'(done_cnt - b_done), 64'd1);
  endtask

  initial begin
    int acc, t, b_done, b_rd, b_wr;
    vecs[0] = '{VAND,     7'd3,  5'd1, 5'd2, 5'd3,  32'hF0F0F0F0, 32'hFF00FF00, 3, 32'hF000F000, 32'hFFFFFFFF, 1'b0};
    vecs[1] = '{VMANDNOT, 7'd40, 5'd4, 5'd5, 5'd6,  32'hFFFF0000, 32'hFFFFFFFF, 2, 32'h0000FFFF, 32'h000000FF, 1'b0};
    vecs[2] = '{VMXNOR,   7'd32, 5'd7, 5'd8, 5'd9,  32'h12345678, 32'h12345678, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[3] = '{VADD,     7'd5,  5'd1, 5'd1, 5'd2,  32'h1,        32'h2,        0, 32'h0,        32'hFFFFFFFF, 1'b1};
    vecs[4] = '{VOR,      7'd0,  5'd3, 5'd4, 5'd5,  32'h1,        32'h2,        0, 32'h0,        32'hFFFFFFFF, 1'b0};
    vecs[5] = '{VXOR,     7'd2,  5'd10, 5'd11, 5'd31, 32'hAAAA5555, 32'hFFFF0000, 2, 32'h55555555, 32'hFFFFFFFF, 1'b0};
    vecs[6] = '{VMOR,     7'd64, 5'd12, 5'd13, 5'd14, 32'h0000000F, 32'h000000F0, 2, 32'h000000FF, 32'hFFFFFFFF, 1'b0};
    vecs[7] = '{VMNAND,   7'd1,  5'd15, 5'd16, 5'd17, 32'h0000000F, 32'h00000003, 1, 32'hFFFFFFFC, 32'h00000001, 1'b0};
    vecs[8] = '{{OP_NAND, TYPE_INT}, 7'd4, 5'd18, 5'd19, 5'd20, 32'h1, 32'h2, 0, 32'h0, 32'hFFFFFFFF, 1'b1};

    bus.req_valid_i = 1'b0;
    bus.req_ocode_i = '0;
    bus.req_vl_i    = '0;
    bus.req_vs1_i   = '0;
    bus.req_vs2_i   = '0;
    bus.req_vd_i    = '0;
    bus.rd_data1_i  = '0;
    bus.rd_data2_i  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset ready", 64'(bus.req_ready_o), 64'd1);
    check("reset outs", 64'({bus.rd_req_o, bus.wr_req_o, bus.done_o, bus.err_o, bus.logic_e_o}), 64'd0);
    check("reset buses", 64'(bus.wr_bmask_o | bus.logic_a_o | bus.wr_data_o), 64'd0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // Delayed handshakes, then reset while beat 1 waits in write-back.
    rd_dly = 4;
    wr_dly = 2;
    b_wr = wr_n;
    b_done = done_cnt;
    run_req(vecs[0], acc);
    #1;
    t = 0;
    while (!(bus.wr_req_o && wr_n == b_wr + 1) && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("rst wb beat1 reached", 64'(bus.wr_req_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst clears outs", 64'({bus.rd_req_o, bus.wr_req_o, bus.done_o, bus.err_o, bus.logic_e_o}), 64'd0);
    check("rst ready", 64'(bus.req_ready_o), 64'd1);
    check("rst bmask", 64'(bus.wr_bmask_o), 64'd0);
    rst = 1'b0;
    b_rd = rd_cycles;
    repeat (8) @(negedge clk);
    #1;
    check("rst no done", 64'(done_cnt - b_done), 64'd0);
    check("rst no more writes", 64'(wr_n - b_wr), 64'd1);
    check("rst no more reads", 64'(rd_cycles - b_rd), 64'd0);
    run_vec(vecs[5], "after rst");

    rd_dly = 0;
    wr_dly = 0;
    repeat (2) @(negedge clk);
    check("no stray err", 64'(stray_err), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
